// File: rtl/instr_loader_if.sv
// Byte-stream / instruction-memory bus for the program loader.
// The master side is the host or boot ROM (plus the core watching status);
// the slave side is instr_loader itself.
interface instr_loader_if #(
  parameter int PROG_CTR_WID = 10
);
  logic                    start;
  logic [7:0]              byte_in;
  logic                    byte_valid;
  logic                    byte_ready;
  logic                    wr_en;
  logic [PROG_CTR_WID-1:0] wr_addr;
  logic [15:0]             wr_data;
  logic                    cpu_hold;
  logic                    done;
  logic                    err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: takes a 16-bit big-endian word count followed by
// big-endian instruction words and writes them to instruction memory from
// address 0, holding the core stalled until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte over all data bytes, checked in the CHK state.
module instr_loader #(
  parameter int PROG_CTR_WID = 10
) (
  input  logic              clk,
  input  logic              rst,
  instr_loader_if.slave     bus
);

  localparam logic [16:0] CAP = 17'(1) << PROG_CTR_WID;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic                    byte_rdy;
  logic                    byte_acc;
  logic                    start_acc;
  logic [7:0]              len_hi_p0;
  logic [15:0]             len_p0;
  logic [15:0]             len_full;
  logic                    len_bad;
  logic [7:0]              hi_byte_p0;
  logic [15:0]             cnt_q;
  logic                    last_word;
  logic                    wr_en_p1;
  logic [PROG_CTR_WID-1:0] wr_addr_q;
  logic [15:0]             wr_data_p1;
  logic                    hold_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum_q;
`endif

  assign byte_acc  = bus.byte_valid && byte_rdy;
  assign start_acc = bus.start &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign len_full  = {len_hi_p0, bus.byte_in};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > CAP);
  assign last_word = (cnt_q == (len_p0 - 16'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: advance only on accepted bytes or an honoured start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_LEN_HI;
      S_LEN_HI:  if (byte_acc) state_d = S_LEN_LO;
      S_LEN_LO:  if (byte_acc) state_d = len_bad ? S_ERR : S_DATA_HI;
      S_DATA_HI: if (byte_acc) state_d = S_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
      S_DATA_LO: if (byte_acc) state_d = last_word ? S_CHK : S_DATA_HI;
      S_CHK:     if (byte_acc) state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERR;
`else
      S_DATA_LO: if (byte_acc) state_d = last_word ? S_DONE : S_DATA_HI;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: the stream is only consumed while a load is in progress
  always_comb begin
    byte_rdy = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: byte_rdy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:   byte_rdy = 1'b1;
`endif
      default: byte_rdy = 1'b0;
    endcase
  end

  // Header and high-byte capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (byte_acc && state_q == S_LEN_HI)  len_hi_p0  <= bus.byte_in;
    if (byte_acc && state_q == S_LEN_LO)  len_p0     <= len_full;
    if (byte_acc && state_q == S_DATA_HI) hi_byte_p0 <= bus.byte_in;
  end

  // Write port: one-cycle strobe per word; address saturates so it never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_p1   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_p1 <= '0;
      cnt_q      <= '0;
    end else begin
      wr_en_p1 <= byte_acc && (state_q == S_DATA_LO);
      if (byte_acc && state_q == S_DATA_LO) begin
        wr_data_p1 <= {hi_byte_p0, bus.byte_in};
        cnt_q      <= cnt_q + 16'd1;
      end
      if (start_acc) begin
        wr_addr_q <= '0;
        cnt_q     <= '0;
      end else if (wr_en_p1 && (wr_addr_q != '1)) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every data byte in the image
  always_ff @(posedge clk) begin
    if (rst || start_acc) csum_q <= '0;
    else if (byte_acc && (state_q == S_DATA_HI || state_q == S_DATA_LO))
      csum_q <= csum_q ^ bus.byte_in;
  end
`endif

  // Status: done waits for the final write strobe to retire before releasing the core
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (start_acc) begin
      hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == S_DONE && !wr_en_p1) begin
      hold_q <= 1'b0;
      done_q <= 1'b1;
    end else if (state_q == S_ERR) begin
      hold_q <= 1'b0;
      err_q  <= 1'b1;
    end
  end

  assign bus.byte_ready = byte_rdy;
  assign bus.wr_en      = wr_en_p1;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_p1;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (small 16-word memory).
module tb_instr_loader;

  localparam int W   = 4;
  localparam int CAP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_loader_if #(.PROG_CTR_WID(W)) bus();
  instr_loader #(.PROG_CTR_WID(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct { logic [W-1:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];

  typedef struct { int n; bit gap; logic [15:0] seed; bit exp_err; int exp_addr; } vec_t;
  vec_t vt[8];

  logic [15:0] img[0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected word
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        check("spurious_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waitc;
    if (gap) begin
      int g;
      g = $urandom_range(0, 3);
      bus.byte_valid = 1'b0;
      for (int i = 0; i < g; i++) begin
        bus.start = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
      bus.start = 1'b0;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    waitc = 0;
    while (bus.byte_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.byte_ready !== 1'b1) check("byte_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_hold", bus.cpu_hold, 1);
    check("start_ready", bus.byte_ready, 1);
    check("start_done_clr", bus.done, 0);
    check("start_err_clr", bus.err, 0);
  endtask

  task automatic load_image(input int n, input bit gap, input bit exp_err,
                            input int exp_addr, input bit bad_chk);
    logic [15:0] nn;
    logic [7:0]  cs;
    wr_t         e;
    nn = 16'(n);
    cs = 8'h00;
    pulse_start();
    send_byte(nn[15:8], gap);
    send_byte(nn[7:0], gap);
    bus.byte_valid = 1'b0;
    if (exp_err) begin
      check("len_ready", bus.byte_ready, 0);
      check("len_err_early", bus.err, 0);
      @(negedge clk);
      check("len_err", bus.err, 1);
      check("len_hold", bus.cpu_hold, 0);
      check("len_done", bus.done, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        e.addr = W'(i);
        e.data = img[i];
        exp_q.push_back(e);
        send_byte(img[i][15:8], gap);
        send_byte(img[i][7:0], gap);
        cs = cs ^ img[i][15:8] ^ img[i][7:0];
      end
      bus.byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      check("chk_wait_done", bus.done, 0);
      check("chk_ready", bus.byte_ready, 1);
      send_byte(bad_chk ? (cs ^ 8'h01) : cs, gap);
      bus.byte_valid = 1'b0;
      check("chk_done_early", bus.done, 0);
      @(negedge clk);
      check("chk_done", bus.done, bad_chk ? 0 : 1);
      check("chk_err", bus.err, bad_chk ? 1 : 0);
      check("chk_hold", bus.cpu_hold, 0);
`else
      check("done_k1", bus.done, 0);
      check("hold_k1", bus.cpu_hold, 1);
      check("ready_k1", bus.byte_ready, 0);
      @(negedge clk);
      check("done_k2", bus.done, 0);
      @(negedge clk);
      check("done_final", bus.done, bad_chk ? 1 : 1);
      check("hold_final", bus.cpu_hold, 0);
      check("err_final", bus.err, 0);
`endif
    end
    check("queue_empty", exp_q.size(), 0);
    check("final_addr", 32'(bus.wr_addr), exp_addr);
    // Bytes offered while idle must not be consumed
    bus.byte_in    = 8'hA5;
    bus.byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", bus.byte_ready, 0);
    end
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1,   1'b0, 16'h0F0F, 1'b0, 1};
    vt[1] = '{3,   1'b1, 16'h1357, 1'b0, 3};
    vt[2] = '{16,  1'b0, 16'h8001, 1'b0, 15};
    vt[3] = '{16,  1'b1, 16'h8001, 1'b0, 15};
    vt[4] = '{17,  1'b0, 16'h0000, 1'b1, 0};
    vt[5] = '{0,   1'b0, 16'h0000, 1'b1, 0};
    vt[6] = '{5,   1'b1, 16'h7E11, 1'b0, 5};
    vt[7] = '{256, 1'b1, 16'h0000, 1'b1, 0};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.byte_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_hold", bus.cpu_hold, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word image, back-to-back bytes
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    load_image(2, 1'b0, 1'b0, 2, 1'b0);

    // Table-driven loads
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 32; i++) img[i] = vt[k].seed ^ 16'(i * 16'h2F31);
      load_image(vt[k].n, vt[k].gap, vt[k].exp_err, vt[k].exp_addr, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum 0x40 accepted, 0x41 rejected (writes still happen)
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    load_image(2, 1'b0, 1'b0, 2, 1'b0);
    load_image(2, 1'b1, 1'b0, 2, 1'b1);
`endif

    // Reset in the middle of a load
    for (int i = 0; i < 4; i++) img[i] = 16'h5A00 + 16'(i * 16'h0111);
    begin
      wr_t e;
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h04, 1'b0);
      e.addr = '0;
      e.data = img[0];
      exp_q.push_back(e);
      send_byte(img[0][15:8], 1'b0);
      send_byte(img[0][7:0], 1'b0);
      send_byte(img[1][15:8], 1'b0);
      bus.byte_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_ready", bus.byte_ready, 0);
      check("mid_rst_wr_en", bus.wr_en, 0);
      check("mid_rst_wr_addr", 32'(bus.wr_addr), 0);
      check("mid_rst_wr_data", 32'(bus.wr_data), 0);
      check("mid_rst_hold", bus.cpu_hold, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_err", bus.err, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_rst_queue", exp_q.size(), 0);
      load_image(4, 1'b0, 1'b0, 4, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
